hci_ecc_scrubber: RTL and testbench

// - Background ECC scrubber for one TCDM bank port, on the memory side of the hci ECC decoder.
// - Periodically reads every word of a range and shares the bank port with core traffic.
// - Uses the decoder error flags to write back corrected data on single-bit errors.
// - Counts corrected and uncorrectable errors.

---
 rtl/hci_ecc_scrubber.sv | 193 +++++++++++++++++++
 tb/tb_hci_ecc_scrubber.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_ecc_scrubber.sv
// rtl/hci_ecc_scrubber.sv - background ECC scrubber sharing one TCDM bank port; optional error log via HCI_ECC_SCRUB_LOG_EN
module hci_ecc_scrubber #(
  parameter int unsigned   AW         = 32,
  parameter int unsigned   DW         = 32,
  parameter int unsigned   NUM_WORDS  = 1024,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter int unsigned   INTERVAL_W = 16,
  parameter int unsigned   MAX_STALL  = 15,
  parameter int unsigned   CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scrub_en_i,
  input  logic [INTERVAL_W-1:0] interval_i,
  input  logic                  core_req_i,
  output logic                  core_gnt_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_sel_scrub_o,
  output logic [AW-1:0]         mem_add_o,
  output logic                  mem_wen_o,
  output logic [DW-1:0]         mem_data_o,
  input  logic                  mem_r_valid_i,
  input  logic [DW-1:0]         mem_r_data_i,
  input  logic                  single_err_i,
  input  logic                  multi_err_i,
  output logic [CNT_W-1:0]      fix_cnt_o,
  output logic [CNT_W-1:0]      uncorr_cnt_o,
  output logic                  pass_done_o,
  output logic                  busy_o
`ifdef HCI_ECC_SCRUB_LOG_EN
  ,
  output logic [AW-1:0]         err_addr_o,
  output logic                  err_valid_o
`endif
);

  localparam int unsigned   IW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned   SW         = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_WORDS - 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(MAX_STALL);
  localparam logic [AW-1:0] WORD_BYTES = AW'(DW / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         index_q, index_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [SW-1:0]         stall_q, stall_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]      fix_q, fix_d;
  logic [CNT_W-1:0]      uncorr_q, uncorr_d;
  logic                  pass_q, pass_d;
  logic                  issue;
  logic                  advance;

  assign mem_add_o    = BASE_ADDR + AW'(index_q) * WORD_BYTES;
  assign mem_wen_o    = (state_q != S_WRITE);
  assign mem_data_o   = wdata_q;
  assign fix_cnt_o    = fix_q;
  assign uncorr_cnt_o = uncorr_q;
  assign pass_done_o  = pass_q;
  assign busy_o       = (state_q != S_IDLE);

  // Next-state, port arbitration and bookkeeping; the scrub only owns the port while issuing
  always_comb begin
    state_d         = state_q;
    index_d         = index_q;
    interval_d      = interval_q;
    stall_d         = stall_q;
    wdata_d         = wdata_q;
    fix_d           = fix_q;
    uncorr_d        = uncorr_q;
    pass_d          = 1'b0;
    advance         = 1'b0;
    mem_req_o       = core_req_i;
    core_gnt_o      = mem_gnt_i;
    mem_sel_scrub_o = 1'b0;
    issue           = ((state_q == S_READ) || (state_q == S_WRITE)) &&
                      (!core_req_i || (stall_q == STALL_MAX));

    case (state_q)
      S_IDLE: begin
        if (!scrub_en_i) begin
          interval_d = '0;
        end else if (interval_q == interval_i) begin
          interval_d = '0;
          state_d    = S_READ;
        end else begin
          interval_d = interval_q + INTERVAL_W'(1);
        end
      end
      S_READ, S_WRITE: begin
        if (issue) begin
          mem_req_o       = 1'b1;
          core_gnt_o      = 1'b0;
          mem_sel_scrub_o = 1'b1;
          if (mem_gnt_i) begin
            stall_d = '0;
            if (state_q == S_READ) state_d = S_WAIT;
            else                   advance = 1'b1;
          end
        end else begin
          // Blocked by the core; issue only happens at STALL_MAX so this cannot overflow
          stall_d = stall_q + SW'(1);
        end
      end
      S_WAIT: begin
        mem_req_o  = 1'b0;
        core_gnt_o = 1'b0;
        if (mem_r_valid_i && multi_err_i) begin
          if (uncorr_q != '1) uncorr_d = uncorr_q + CNT_W'(1);
          advance = 1'b1;
        end else if (mem_r_valid_i && single_err_i) begin
          if (fix_q != '1) fix_d = fix_q + CNT_W'(1);
          wdata_d = mem_r_data_i;
          state_d = S_WRITE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      state_d = S_IDLE;
      if (index_q == LAST_IDX) begin
        index_d = '0;
        pass_d  = 1'b1;
      end else begin
        index_d = index_q + IW'(1);
      end
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      interval_q <= '0;
      stall_q    <= '0;
      wdata_q    <= '0;
      fix_q      <= '0;
      uncorr_q   <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      interval_q <= interval_d;
      stall_q    <= stall_d;
      wdata_q    <= wdata_d;
      fix_q      <= fix_d;
      uncorr_q   <= uncorr_d;
      pass_q     <= pass_d;
    end
  end

`ifdef HCI_ECC_SCRUB_LOG_EN
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic          err_valid_q, err_valid_d;

  // Remember the address of the latest decoder error; valid stays set until reset
  always_comb begin
    err_addr_d  = err_addr_q;
    err_valid_d = err_valid_q;
    if ((state_q == S_WAIT) && mem_r_valid_i && (single_err_i || multi_err_i)) begin
      err_addr_d  = mem_add_o;
      err_valid_d = 1'b1;
    end
  end

  // Error log registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign err_addr_o  = err_addr_q;
  assign err_valid_o = err_valid_q;
`endif

endmodule

// File: tb/tb_hci_ecc_scrubber.sv
// tb/tb_hci_ecc_scrubber.sv - directed self-checking bench for hci_ecc_scrubber
module tb_hci_ecc_scrubber;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clk, rst, scrub_en, core_req, core_gnt, mem_req, mem_gnt, sel, wen;
  logic [15:0] interval;
  logic [31:0] add, wdata, r_data;
  logic        r_valid, single_err, multi_err, pass_done, busy;
  logic [15:0] fix, uncorr;

  logic        s_core_gnt, s_mem_req, s_sel, s_wen, s_pass_done, s_busy;
  logic [31:0] s_add, s_wdata;
  logic [1:0]  s_fix, s_uncorr;

  logic        gnt_en, single_all, last_scrub_rd;
  logic [31:0] single_addr, multi_addr, last_addr;
  int          cycle, pass_cnt, pass_base;
  int          errors, checks;
  logic [31:0] rd_q[$], wr_a[$], wr_d[$];
  int          rd_cyc[$];

  hci_ecc_scrubber #(.NUM_WORDS(4), .MAX_STALL(15)) dut (
    .clk_i(clk), .rst_i(rst), .scrub_en_i(scrub_en), .interval_i(interval),
    .core_req_i(core_req), .core_gnt_o(core_gnt), .mem_req_o(mem_req), .mem_gnt_i(mem_gnt),
    .mem_sel_scrub_o(sel), .mem_add_o(add), .mem_wen_o(wen), .mem_data_o(wdata),
    .mem_r_valid_i(r_valid), .mem_r_data_i(r_data), .single_err_i(single_err),
    .multi_err_i(multi_err), .fix_cnt_o(fix), .uncorr_cnt_o(uncorr),
    .pass_done_o(pass_done), .busy_o(busy)
  );

  // Same stimulus, 2-bit counters: exposes counter saturation quickly
  hci_ecc_scrubber #(.NUM_WORDS(4), .MAX_STALL(15), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .scrub_en_i(scrub_en), .interval_i(interval),
    .core_req_i(core_req), .core_gnt_o(s_core_gnt), .mem_req_o(s_mem_req), .mem_gnt_i(mem_gnt),
    .mem_sel_scrub_o(s_sel), .mem_add_o(s_add), .mem_wen_o(s_wen), .mem_data_o(s_wdata),
    .mem_r_valid_i(r_valid), .mem_r_data_i(r_data), .single_err_i(single_err),
    .multi_err_i(multi_err), .fix_cnt_o(s_fix), .uncorr_cnt_o(s_uncorr),
    .pass_done_o(s_pass_done), .busy_o(s_busy)
  );

  assign r_data     = 32'hDEADBEEF;
  assign mem_gnt    = gnt_en & mem_req;
  assign single_err = r_valid && last_scrub_rd && (single_all || last_addr == single_addr);
  assign multi_err  = r_valid && last_scrub_rd && (last_addr == multi_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bank model (response one cycle after grant) and transaction log
  always @(posedge clk) begin
    cycle         <= cycle + 1;
    r_valid       <= !rst && mem_req && mem_gnt;
    last_scrub_rd <= sel && wen;
    last_addr     <= add;
    if (!rst && mem_req && mem_gnt && sel) begin
      if (wen) begin
        rd_q.push_back(add);
        rd_cyc.push_back(cycle);
      end else begin
        wr_a.push_back(add);
        wr_d.push_back(wdata);
      end
    end
    if (!rst && pass_done) pass_cnt <= pass_cnt + 1;
  end

  task automatic do_reset();
    rst = 1'b1; scrub_en = 1'b0; interval = 16'd0; core_req = 1'b0; gnt_en = 1'b1;
    single_addr = NONE; multi_addr = NONE; single_all = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_q.delete(); rd_cyc.delete(); wr_a.delete(); wr_d.delete();
    pass_base = pass_cnt;
  endtask

  task automatic settle();
    scrub_en = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL settle_idle busy=%0b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; scrub_en = 1'b0; interval = 16'd0; core_req = 1'b0; gnt_en = 1'b0;
    single_addr = NONE; multi_addr = NONE; single_all = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (add !== 32'd0)      begin errors++; $display("FAIL rst_add got %h want 0", add); end
    checks++; if (wen !== 1'b1)       begin errors++; $display("FAIL rst_wen got %0b want 1", wen); end
    checks++; if (fix !== 16'd0)      begin errors++; $display("FAIL rst_fix got %h want 0", fix); end
    checks++; if (uncorr !== 16'd0)   begin errors++; $display("FAIL rst_uncorr got %h want 0", uncorr); end
    checks++; if (pass_done !== 1'b0) begin errors++; $display("FAIL rst_pass got %0b want 0", pass_done); end
    checks++; if ({mem_req, sel, core_gnt} !== 3'b000)
      begin errors++; $display("FAIL rst_port got %b want 000", {mem_req, sel, core_gnt}); end
  endtask

  task automatic test_scan();
    logic [31:0] exp_a[5];
    exp_a = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0};
    do_reset();
    interval = 16'd3; scrub_en = 1'b1;
    for (int i = 0; i < 200 && rd_q.size() < 5; i++) @(negedge clk);
    settle();
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() != 5) begin errors++; $display("FAIL scan_reads got %0d want 5", rd_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rd_q[i] !== exp_a[i]) begin errors++; $display("FAIL scan_addr%0d got %h want %h", i, rd_q[i], exp_a[i]); end
      end
      checks++;
      if (rd_cyc[1] - rd_cyc[0] != 6) begin errors++; $display("FAIL scan_period got %0d want 6", rd_cyc[1] - rd_cyc[0]); end
    end
    checks++; if (pass_cnt - pass_base != 1) begin errors++; $display("FAIL scan_pass got %0d want 1", pass_cnt - pass_base); end
    checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL scan_writes got %0d want 0", wr_a.size()); end
    checks++; if ({fix, uncorr} !== 32'd0) begin errors++; $display("FAIL scan_cnts got %h want 0", {fix, uncorr}); end
  endtask

  task automatic test_single_err();
    do_reset();
    single_addr = 32'd8; scrub_en = 1'b1;
    for (int i = 0; i < 200 && rd_q.size() < 4; i++) @(negedge clk);
    settle();
    checks++;
    if (wr_a.size() != 1) begin errors++; $display("FAIL single_writes got %0d want 1", wr_a.size()); end
    else begin
      checks++; if (wr_a[0] !== 32'd8) begin errors++; $display("FAIL single_waddr got %h want 8", wr_a[0]); end
      checks++; if (wr_d[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got %h want deadbeef", wr_d[0]); end
    end
    checks++; if (fix !== 16'd1) begin errors++; $display("FAIL single_fix got %h want 1", fix); end
    checks++; if (uncorr !== 16'd0) begin errors++; $display("FAIL single_uncorr got %h want 0", uncorr); end
    checks++;
    if (rd_q.size() < 4 || rd_q[3] !== 32'd12) begin errors++; $display("FAIL single_next_rd got %h want c", rd_q.size() < 4 ? NONE : rd_q[3]); end
  endtask

  task automatic test_multi_err();
    do_reset();
    multi_addr = 32'd4; scrub_en = 1'b1;
    for (int i = 0; i < 200 && rd_q.size() < 3; i++) @(negedge clk);
    settle();
    checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL multi_writes got %0d want 0", wr_a.size()); end
    checks++; if (uncorr !== 16'd1) begin errors++; $display("FAIL multi_uncorr got %h want 1", uncorr); end
    checks++; if (fix !== 16'd0) begin errors++; $display("FAIL multi_fix got %h want 0", fix); end
    checks++;
    if (rd_q.size() < 3 || rd_q[2] !== 32'd8) begin errors++; $display("FAIL multi_next_rd got %h want 8", rd_q.size() < 3 ? NONE : rd_q[2]); end
    // Both flags together count as uncorrectable
    do_reset();
    single_addr = 32'd0; multi_addr = 32'd0; scrub_en = 1'b1;
    for (int i = 0; i < 200 && rd_q.size() < 2; i++) @(negedge clk);
    settle();
    checks++;
    if ({wr_a.size() == 0, fix, uncorr} !== {1'b1, 16'd0, 16'd1})
      begin errors++; $display("FAIL both_err writes=%0d fix=%h uncorr=%h want 0/0/1", wr_a.size(), fix, uncorr); end
  endtask

  task automatic test_stall();
    int  n;
    logic done;
    do_reset();
    core_req = 1'b1; scrub_en = 1'b1;
    n = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        if (n == 1) begin
          checks++;
          if ({core_gnt, sel} !== 2'b10) begin errors++; $display("FAIL stall_passthru gnt,sel=%b want 10", {core_gnt, sel}); end
        end
        if (mem_req && sel) begin
          done = 1'b1;
          checks++;
          if (core_gnt !== 1'b0) begin errors++; $display("FAIL stall_issue_gnt got %0b want 0", core_gnt); end
        end
      end
    end
    checks++; if (n != 16) begin errors++; $display("FAIL stall_cycles got %0d want 16", n); end
    @(negedge clk);
    checks++;
    if ({busy, core_gnt, mem_req} !== 3'b100) begin errors++; $display("FAIL stall_wait busy,gnt,req=%b want 100", {busy, core_gnt, mem_req}); end
    core_req = 1'b0;
    settle();
  endtask

  task automatic test_en_drop_write();
    int  bad;
    logic found;
    do_reset();
    single_addr = 32'd0; scrub_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (busy && !wen) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL drop_reach_write got 0 want 1"); end
    scrub_en = 1'b0; gnt_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, wen, mem_req, sel} !== 4'b1011) begin errors++; $display("FAIL drop_hold got %b want 1011", {busy, wen, mem_req, sel}); end
    gnt_en = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_a.size() != 1 || wr_a[0] !== 32'd0 || wr_d[0] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL drop_write_done writes=%0d want 1 at 0 with deadbeef", wr_a.size()); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL drop_stay_idle busy_cycles=%0d want 0", bad); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    multi_addr = 32'd0; scrub_en = 1'b1;
    for (int i = 0; i < 60 && uncorr !== 16'd1; i++) @(negedge clk);
    core_req = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    checks++;
    if ({busy, add} !== {1'b1, 32'd4}) begin errors++; $display("FAIL rmid_pre busy=%0b add=%h want 1/4", busy, add); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, add, fix, uncorr} !== {1'b0, 32'd0, 16'd0, 16'd0})
      begin errors++; $display("FAIL rmid_post busy=%0b add=%h fix=%h uncorr=%h want 0", busy, add, fix, uncorr); end
    rst = 1'b0; core_req = 1'b0; scrub_en = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    single_all = 1'b1; scrub_en = 1'b1;
    for (int i = 0; i < 300 && fix !== 16'd4; i++) @(negedge clk);
    settle();
    checks++; if (fix !== 16'd4) begin errors++; $display("FAIL sat_wide_fix got %h want 4", fix); end
    checks++; if (s_fix !== 2'b11) begin errors++; $display("FAIL sat_fix got %b want 11", s_fix); end
    checks++; if (wr_a.size() != 4) begin errors++; $display("FAIL sat_writes got %0d want 4", wr_a.size()); end
  endtask

  initial begin
    errors = 0; checks = 0;
    cycle = 0; pass_cnt = 0; pass_base = 0;
    test_reset();
    test_scan();
    test_single_err();
    test_multi_err();
    test_stall();
    test_en_drop_write();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
